// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared state encoding and AHB transfer-type constants for the AHB-to-APB bridge
package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WDATA,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } bridge_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_slave_decoder.sv
// rtl/apb_slave_decoder.sv - slave index to one-hot APB select with decode-miss flag
module apb_slave_decoder #(
    parameter int NUM_SLAVES = 4,
    localparam int SEL_W = $clog2(NUM_SLAVES)
) (
    input  logic [SEL_W-1:0]      idx,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  miss
);

    always_comb begin
        sel  = '0;
        miss = 1'b1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(idx) == i) begin
                sel[i] = 1'b1;
                miss   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/ahb_apb_bridge.sv
// rtl/ahb_apb_bridge.sv - AHB-Lite slave to multi-slave APB master bridge with error and timeout handling
module ahb_apb_bridge
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NUM_SLAVES = 4,
    parameter int DEC_LSB    = 12,
    parameter int TIMEOUT    = 0
) (
    input  logic                         clk,
    input  logic                         preset,
    input  logic                         hsel,
    input  logic                         hwrite,
    input  logic                         hready_in,
    input  logic [1:0]                   htrans,
    input  logic [ADDR_W-1:0]            haddr,
    input  logic [DATA_W-1:0]            hwdata,
    output logic                         hreadyout,
    output logic                         hresp,
    output logic [DATA_W-1:0]            hrdata,
    output logic [NUM_SLAVES-1:0]        psel,
    output logic                         penable,
    output logic                         pwrite,
    output logic [ADDR_W-1:0]            paddr,
    output logic [DATA_W-1:0]            pwdata,
    input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]        pready,
    input  logic [NUM_SLAVES-1:0]        pslverr
);

    localparam int SEL_W = $clog2(NUM_SLAVES);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    bridge_state_t         state, state_nxt;
    logic [NUM_SLAVES-1:0] sel_q, dec_sel;
    logic                  dec_miss;
    logic [CNT_W-1:0]      wait_cnt;
    logic                  valid, accept, sel_ready, sel_err, done, timeout_hit;
    logic [DATA_W-1:0]     sel_rdata;

    apb_slave_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
        .idx  (haddr[DEC_LSB +: SEL_W]),
        .sel  (dec_sel),
        .miss (dec_miss)
    );

    assign valid = hsel && hready_in && !(htrans inside {HTRANS_IDLE, HTRANS_BUSY});

    // psel is one-hot and registered, so it masks out every non-selected slave
    assign sel_ready = |(pready & psel);
    assign sel_err   = |(pslverr & psel);
    assign done      = (state == ST_ACCESS) && sel_ready && !sel_err;
    assign accept    = valid && (state == ST_IDLE || state == ST_ERR2 || done);

    assign timeout_hit = (TIMEOUT != 0) && !sel_ready && (int'(wait_cnt) + 1 == TIMEOUT);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (psel[i]) sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
        end
    end

    always_comb begin
        state_nxt = state;
        hreadyout = 1'b1;
        hresp     = 1'b0;
        hrdata    = '0;
        unique case (state)
            ST_IDLE: ;
            ST_WDATA: begin
                hreadyout = 1'b0;
                state_nxt = ST_SETUP;
            end
            ST_SETUP: begin
                hreadyout = 1'b0;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                hreadyout = done;
                if (done) begin
                    if (!pwrite) hrdata = sel_rdata;
                    state_nxt = ST_IDLE;
                end else if (sel_ready || timeout_hit) begin
                    state_nxt = ST_ERR1;
                end
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
                state_nxt = ST_ERR2;
            end
            ST_ERR2: begin
                hresp     = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (accept) state_nxt = dec_miss ? ST_ERR1 : (hwrite ? ST_WDATA : ST_SETUP);
    end

    always_ff @(posedge clk) begin
        if (preset) begin
            state    <= ST_IDLE;
            psel     <= '0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            sel_q    <= '0;
            wait_cnt <= '0;
        end else begin
            state   <= state_nxt;
            penable <= (state_nxt == ST_ACCESS);
            if (state_nxt == ST_SETUP || state_nxt == ST_ACCESS)
                psel <= accept ? dec_sel : sel_q;
            else
                psel <= '0;
            if (accept && !dec_miss) begin
                sel_q  <= dec_sel;
                paddr  <= haddr;
                pwrite <= hwrite;
            end
            if (state == ST_WDATA) pwdata <= hwdata;
            // saturates rather than wrapping so an unbounded wait never looks fresh
            if (state_nxt == ST_SETUP)
                wait_cnt <= '0;
            else if (state == ST_ACCESS && !sel_ready && wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// tb/tb_ahb_apb_bridge.sv - self-checking bench for ahb_apb_bridge against a transfer-level timeline model
module tb_ahb_apb_bridge;
    import ahb_apb_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         preset, hsel, hwrite, hready_in, use3;
    logic [1:0]   htrans;
    logic [31:0]  haddr, hwdata;
    logic [127:0] prdata;
    logic [3:0]   pready, pslverr;

    logic        hreadyout_a, hresp_a, penable_a, pwrite_a;
    logic [31:0] hrdata_a, paddr_a, pwdata_a;
    logic [3:0]  psel_a;
    logic        hreadyout_b, hresp_b, penable_b, pwrite_b;
    logic [31:0] hrdata_b, paddr_b, pwdata_b;
    logic [2:0]  psel_b;

    ahb_apb_bridge dut (
        .clk(clk), .preset(preset), .hsel(hsel & ~use3), .hwrite(hwrite), .hready_in(hready_in),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout_a), .hresp(hresp_a),
        .hrdata(hrdata_a), .psel(psel_a), .penable(penable_a), .pwrite(pwrite_a), .paddr(paddr_a),
        .pwdata(pwdata_a), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    ahb_apb_bridge #(.NUM_SLAVES(3), .TIMEOUT(8)) dut3 (
        .clk(clk), .preset(preset), .hsel(hsel & use3), .hwrite(hwrite), .hready_in(hready_in),
        .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout_b), .hresp(hresp_b),
        .hrdata(hrdata_b), .psel(psel_b), .penable(penable_b), .pwrite(pwrite_b), .paddr(paddr_b),
        .pwdata(pwdata_b), .prdata(prdata[95:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0])
    );

    logic [31:0] o_hreadyout, o_hresp, o_hrdata, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata;
    assign o_hreadyout = 32'(use3 ? hreadyout_b : hreadyout_a);
    assign o_hresp     = 32'(use3 ? hresp_b : hresp_a);
    assign o_hrdata    = use3 ? hrdata_b : hrdata_a;
    assign o_psel      = use3 ? {29'b0, psel_b} : {28'b0, psel_a};
    assign o_penable   = 32'(use3 ? penable_b : penable_a);
    assign o_pwrite    = 32'(use3 ? pwrite_b : pwrite_a);
    assign o_paddr     = use3 ? paddr_b : paddr_a;
    assign o_pwdata    = use3 ? pwdata_b : pwdata_a;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hreadyout"}, o_hreadyout, 32'd1);
        chk({tag, "_hresp"}, o_hresp, 32'd0);
        chk({tag, "_hrdata"}, o_hrdata, 32'd0);
        chk({tag, "_psel"}, o_psel, 32'd0);
        chk({tag, "_penable"}, o_penable, 32'd0);
        chk({tag, "_pwrite"}, o_pwrite, 32'd0);
        chk({tag, "_paddr"}, o_paddr, 32'd0);
        chk({tag, "_pwdata"}, o_pwdata, 32'd0);
    endtask

    // One AHB transfer. Expectations come from a cycle timeline: pre-access cycles
    // (WDATA for writes, then SETUP), waits+1 ACCESS cycles (capped by the timeout),
    // then two error cycles when the transfer fails.
    task automatic xfer(input bit w, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdv, input int waits, input bit slverr,
                        input bit pre, input bit chain, input bit cw, input logic [31:0] caddr);
        int idx, n_pre, acc_n, last, total, fire, to_lim, n_sl;
        bit miss, err;
        logic [3:0] oh, nz;
        idx    = int'(addr[13:12]);
        n_sl   = use3 ? 3 : 4;
        to_lim = use3 ? 8 : 0;
        miss   = (idx >= n_sl);
        oh     = 4'b0001 << idx;
        for (int s = 0; s < 4; s++) prdata[s*32 +: 32] = $urandom;
        prdata[idx*32 +: 32] = rdv;
        if (miss) begin
            n_pre = 0; acc_n = 0; err = 1'b1;
        end else begin
            n_pre = w ? 2 : 1;
            if (to_lim != 0 && waits >= to_lim) begin
                acc_n = to_lim; err = 1'b1;
            end else begin
                acc_n = waits + 1; err = slverr;
            end
        end
        last  = n_pre + acc_n;
        total = last + (err ? 2 : 0);
        fire  = n_pre + waits + 1;
        if (!pre) begin
            @(negedge clk);
            hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = w; haddr = addr;
            pready = 4'b0; pslverr = 4'b0;
            #1;
            chk("addr_phase_hreadyout", o_hreadyout, 32'd1);
            chk("addr_phase_hresp", o_hresp, 32'd0);
        end
        for (int c = 1; c <= total; c++) begin
            @(negedge clk);
            hwdata = w ? wd : $urandom;
            if (c == total && chain) begin
                hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = cw; haddr = caddr;
            end else begin
                hsel = 1'($urandom); htrans = HTRANS_IDLE; hwrite = 1'($urandom); haddr = $urandom;
            end
            nz      = 4'($urandom);
            pready  = (nz & ~oh) | ((c == fire) ? oh : 4'b0);
            nz      = 4'($urandom);
            pslverr = (nz & ~oh) | ((c == fire && slverr) ? oh : 4'b0);
            #1;
            chk("hreadyout", o_hreadyout, 32'((c == last) ? !err : (c == total && err)));
            chk("hresp", o_hresp, 32'(c > last));
            chk("penable", o_penable, 32'(c > n_pre && c <= last));
            chk("psel", o_psel, 32'((c >= n_pre && c <= last && !miss) ? oh : 4'b0));
            chk("hrdata", o_hrdata, (c == last && !w && !err) ? rdv : 32'd0);
            if (c >= n_pre && c <= last && !miss) begin
                chk("paddr", o_paddr, addr);
                chk("pwrite", o_pwrite, 32'(w));
                if (w) chk("pwdata", o_pwdata, wd);
            end
        end
    endtask

    initial begin
        bit          pre, ch, w, nw;
        logic [31:0] a, na;
        preset = 1'b1; use3 = 1'b0; hsel = 1'b0; hwrite = 1'b0; hready_in = 1'b1;
        htrans = HTRANS_IDLE; haddr = '0; hwdata = '0; prdata = '0; pready = '0; pslverr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_reset("reset_a");
        use3 = 1'b1;
        #1;
        chk_reset("reset_b");
        use3 = 1'b0;
        preset = 1'b0;

        xfer(1'b0, 32'h0000_1004, 32'h0, 32'hCAFE_0001, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        xfer(1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 32'h0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        xfer(1'b0, 32'h0000_2008, 32'h0, $urandom, 0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_2010);
        xfer(1'b1, 32'h0000_2010, 32'h1234_5678, 32'h0, 1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2020);
        xfer(1'b0, 32'h0000_2020, 32'h0, $urandom, 2, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2024);
        xfer(1'b0, 32'h0000_2024, 32'h0, $urandom, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        xfer(1'b1, 32'h0000_2004, $urandom, 32'h0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0100);
        xfer(1'b0, 32'h0000_0100, 32'h0, $urandom, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        pre = 1'b0;
        w   = 1'($urandom);
        a   = $urandom;
        for (int i = 0; i < 40; i++) begin
            nw = 1'($urandom);
            na = $urandom;
            ch = 1'($urandom);
            xfer(w, a, $urandom, $urandom, $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                 pre, ch, nw, na);
            pre = ch; w = nw; a = na;
        end
        xfer(w, a, $urandom, $urandom, 1, 1'b0, pre, 1'b0, 1'b0, 32'h0);

        use3 = 1'b1;
        xfer(1'b0, 32'h0000_3000, 32'h0, $urandom, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        xfer(1'b0, 32'h0000_0010, 32'h0, $urandom, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        xfer(1'b1, 32'h0000_2000, $urandom, 32'h0, 8, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1000);
        xfer(1'b0, 32'h0000_1000, 32'h0, $urandom, 7, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_3004);
        xfer(1'b0, 32'h0000_3004, 32'h0, $urandom, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        xfer(1'b0, 32'h0000_0020, 32'h0, $urandom, 20, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        @(negedge clk);
        hsel = 1'b1; htrans = HTRANS_NONSEQ; hwrite = 1'b1; haddr = 32'h0000_1040;
        pready = 4'b0; pslverr = 4'b0;
        @(negedge clk);
        hsel = 1'b0; htrans = HTRANS_IDLE; hwdata = 32'hA5A5_5A5A;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_access_penable", o_penable, 32'd1);
        chk("mid_access_pwdata", o_pwdata, 32'hA5A5_5A5A);
        preset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset("abort_b");
        use3 = 1'b0;
        #1;
        chk_reset("abort_a");
        preset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Parametrised AHB-Lite slave to multi-slave APB master bridge, the successor to the single-slave fixed-address bridge. It accepts one AHB transfer at a time and decodes the address to one of `NUM_SLAVES` APB peripherals. It runs the full APB SETUP/ACCESS protocol with wait states and maps `PSLVERR`, decode misses and timeouts onto a two-cycle AHB ERROR response. It sits between the AHB interconnect and the peripheral APB segment.

## Interface
Parameters:
- `ADDR_W`, default 32: address width on both sides.
- `DATA_W`, default 32: data width on both sides.
- `NUM_SLAVES`, default 4: number of APB slaves; must be ≥2. `SEL_W = $clog2(NUM_SLAVES)`.
- `DEC_LSB`, default 12: lowest address bit of the slave index field.
- `TIMEOUT`, default 0: maximum number of ACCESS cycles before abort; 0 disables the timeout.

Ports:
- `clk`  in  1  single clock for both AHB and APB sides.
- `preset`  in  1  synchronous, active-high reset.
- `hsel`, `hwrite`, `hready_in`  in  1 each  AHB select, direction, bus-ready.
- `htrans`  in  2  AHB transfer type; bit 1 set means NONSEQ or SEQ.
- `haddr`  in  `ADDR_W`  AHB address.
- `hwdata`  in  `DATA_W`  AHB write data; valid in the data phase.
- `hreadyout`  out  1  transfer-complete indication to AHB.
- `hresp`  out  1  1 = ERROR.
- `hrdata`  out  `DATA_W`  read data.
- `psel`  out  `NUM_SLAVES`  one-hot APB select.
- `penable`, `pwrite`  out  1 each  APB enable and direction.
- `paddr`  out  `ADDR_W`  APB address.
- `pwdata`  out  `DATA_W`  APB write data.
- `prdata`  in  `NUM_SLAVES*DATA_W`  concatenated read data; slave i occupies bits [i*DATA_W +: DATA_W].
- `pready`, `pslverr`  in  `NUM_SLAVES` each  per-slave ready and error.

## Operation
- **Valid transfer.** A transfer is valid when `hsel & htrans[1] & hready_in` is true at a rising edge. On that edge the bridge registers `haddr`, `hwrite` and the slave index `idx = haddr[DEC_LSB +: SEL_W]`.
- **Decode.** A transfer is mapped when `idx < NUM_SLAVES`; otherwise it is a decode miss.
- **States.** IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- **IDLE.**
  - Valid write, mapped: go to WDATA.
  - Valid read, mapped: go to SETUP.
  - Valid transfer, decode miss: go to ERR1, with no APB activity.
- **WDATA.** Registers `hwdata` into `pwdata` at the end of the cycle, then goes to SETUP.
- **SETUP.** `psel[idx]`=1, `penable`=0. Always goes to ACCESS.
- **ACCESS.** `psel[idx]`=1, `penable`=1.
  - `pready[idx]`=1 and `pslverr[idx]`=0: completes. `hreadyout`=1, `hresp`=0; for a read, `hrdata` = slave idx `prdata` slice.
  - `pready[idx]`=1 and `pslverr[idx]`=1: go to ERR1.
  - `pready[idx]`=0: stay in ACCESS; the wait counter increments.
  - `TIMEOUT`≠0 and the counter reaches `TIMEOUT`: drop `psel` and go to ERR1. A late `pready` is ignored.
- **ERR1.** `hreadyout`=0, `hresp`=1; goes to ERR2.
- **ERR2.** `hreadyout`=1, `hresp`=1.
- **Pipelined next transfer.** In the completing ACCESS cycle or in ERR2, a valid transfer on the same edge is accepted; the next state follows the IDLE rules instead of returning to IDLE.
  - Transfers presented during ERR1 are not sampled (`hready_in`=0).
- **Outputs held stable.** `paddr`, `pwrite` and `pwdata` are held from SETUP through the end of ACCESS. `hrdata` = 0 except in a completing read cycle.
- **Non-selected slaves.** Signals from non-selected slaves are ignored.

## Timing
- **Reset values.** IDLE, `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `hreadyout`=1, `hresp`=0, `hrdata`=0, wait counter = 0.
  - Reset mid-transfer aborts immediately, with no completion on AHB.
- **Latency with a zero-wait slave.**
  - Read: 2 data-phase cycles (SETUP, ACCESS).
  - Write: 3 data-phase cycles (WDATA, SETUP, ACCESS).
  - Each `pready` wait cycle adds 1.
- **Error response.** Exactly 2 cycles: ERR1 then ERR2.
- **`hreadyout`.** 0 in WDATA, SETUP, non-completing ACCESS and ERR1.
- **Combinational paths.** `hreadyout`, `hresp` and `hrdata` in ACCESS are combinational from `pready`/`pslverr`/`prdata`. All APB outputs are registered.
- **Wait counter.** Width `$clog2(TIMEOUT+1)`. Clears on entering SETUP and never wraps.

## Structure
- Package `ahb_apb_pkg`: state enum `bridge_state_t`, and the `HTRANS_IDLE`/`BUSY`/`NONSEQ`/`SEQ` constants.
- Sub-module `apb_slave_decoder`: `idx` to one-hot `psel` plus a `miss` flag. It is purely combinational and parametrised by `NUM_SLAVES`.
- Top-level: FSM, address/data registers, wait counter, read-data mux.

## Test plan
- Read to 0x0000_1004 (slave 1, `pready` tied 1, `prdata[1]`=0xCAFE_0001) -> `psel`=4'b0010; `hreadyout` low 1 cycle; `hrdata`=0xCAFE_0001, `hresp`=0.
- Write 0xDEAD_BEEF to 0x0000_3000, with slave 3 holding `pready`=0 for 3 cycles -> `pwdata` stable through 4 ACCESS cycles; completion on cycle 6 of the data phase.
- Back-to-back read then write, with the second address presented in the completing cycle -> no IDLE cycle between transfers; `psel` deasserts for 0 cycles only if the slave index is unchanged.
- Slave 2 asserts `pslverr` with `pready` -> `hresp`=1 for 2 cycles; `hreadyout` 0 then 1.
- With `NUM_SLAVES`=3, access 0x0000_3000 (idx 3) -> no `psel`, ERR1/ERR2 response.
- With `TIMEOUT`=8 and a slave that never asserts `pready` -> error response after 8 ACCESS cycles. Assert `preset` mid-ACCESS in a rerun -> all outputs at reset values the next cycle.
